// File: rtl/l2_cmd_fifo_pkg.sv
// Shared types and helpers for the L2 multi-write-port command FIFO.
package l2_cmd_fifo_pkg;

    // Sticky error status reported by the FIFO.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } l2_fifo_status_t;

    // Pointer width for a given entry count.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one bit wider than a pointer so DEPTH itself fits.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return ptr_w(depth) + 1;
    endfunction

    // Number of asserted bits in a write-enable vector of up to 32 ports.
    function automatic logic [5:0] popcount_nwr(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + {5'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/l2_fifo_wr_alloc.sv
// Write-slot allocator: maps enabled write ports onto consecutive RAM entries
// starting at tail, in ascending port order (prefix sum of the enables).
module l2_fifo_wr_alloc
    import l2_cmd_fifo_pkg::*;
#(
    parameter int unsigned NWR   = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = ptr_w(DEPTH),
    localparam int unsigned CNT_W = cnt_w(DEPTH),
    localparam int unsigned SEL_W = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic [NWR-1:0]              we_i,
    input  logic [PTR_W-1:0]            tail_i,
    output logic [DEPTH-1:0]            ent_we_o,
    output logic [DEPTH-1:0][SEL_W-1:0] ent_sel_o,
    output logic [CNT_W-1:0]            nw_o
);

    logic [PTR_W-1:0] run;
    logic [PTR_W-1:0] slot;

    // Walk the ports in order; each enabled port takes the next free slot.
    always_comb begin
        ent_we_o  = '0;
        ent_sel_o = '0;
        run       = '0;
        slot      = '0;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (we_i[p]) begin
                slot            = tail_i + run;
                ent_we_o[slot]  = 1'b1;
                ent_sel_o[slot] = SEL_W'(p);
                run             = run + PTR_W'(1);
            end
        end
        nw_o = CNT_W'(popcount_nwr(32'(we_i)));
    end

endmodule

// File: rtl/l2_cmd_fifo_nw.sv
// L2 command FIFO with NWR write ports and one read port. Write groups are
// all-or-nothing against the free space registered at the start of the cycle;
// rejected groups and empty pops raise sticky status bits.
module l2_cmd_fifo_nw
    import l2_cmd_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NWR      = 2,
    parameter int unsigned AFULL_TH = DEPTH - 2,
    localparam int unsigned PTR_W = ptr_w(DEPTH),
    localparam int unsigned CNT_W = cnt_w(DEPTH),
    localparam int unsigned SEL_W = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NWR-1:0][WIDTH-1:0] din,
    input  logic [NWR-1:0]            we,
    input  logic                      re,
    output logic [WIDTH-1:0]          dout,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic [CNT_W-1:0]          count,
    output logic [CNT_W-1:0]          free,
    output logic                      overflow,
    output logic                      underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, full_q, afull_q;
    logic             empty_d, full_d, afull_d;
    l2_fifo_status_t  status_q, status_d;

    logic [DEPTH-1:0]            ent_we;
    logic [DEPTH-1:0][SEL_W-1:0] ent_sel;
    logic [CNT_W-1:0]            nw;
    logic [CNT_W-1:0]            free_w;
    logic [CNT_W-1:0]            nw_acc;
    logic                        accept;
    logic                        rd_acc;

    l2_fifo_wr_alloc #(
        .NWR   (NWR),
        .DEPTH (DEPTH)
    ) u_wr_alloc (
        .we_i      (we),
        .tail_i    (tail_q),
        .ent_we_o  (ent_we),
        .ent_sel_o (ent_sel),
        .nw_o      (nw)
    );

    // Acceptance, pointer, occupancy and flag next-state logic.
    always_comb begin
        free_w   = CNT_W'(DEPTH) - count_q;
        accept   = (nw <= free_w);
        nw_acc   = accept ? nw : '0;
        rd_acc   = re & ~empty_q;
        count_d  = count_q + nw_acc - CNT_W'(rd_acc);
        head_d   = head_q + PTR_W'(rd_acc);
        tail_d   = tail_q + nw_acc[PTR_W-1:0];
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_W'(DEPTH));
        afull_d  = (32'(count_d) >= AFULL_TH);
        status_d = status_q;
        if (!accept) begin
            status_d.overflow = 1'b1;
        end
        if (re && empty_q) begin
            status_d.underflow = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= (AFULL_TH == 0);
            status_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            status_q <= status_d;
        end
    end

    // Payload RAM: only written by an accepted group, never reset.
    always_ff @(posedge clk) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (rst && accept && ent_we[e]) begin
                mem_q[e] <= din[ent_sel[e]];
            end
        end
    end

    assign dout        = mem_q[head_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign free        = free_w;
    assign overflow    = status_q.overflow;
    assign underflow   = status_q.underflow;

`ifndef SYNTHESIS
    // Simulation checks on configuration and control-input integrity.
    always_ff @(posedge clk) begin
        assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
        assert (NWR >= 1 && NWR <= DEPTH && NWR <= 32);
        if (rst) begin
            assert (!$isunknown(we) && !$isunknown(re));
        end
    end
`endif

endmodule

// File: tb/tb_l2_cmd_fifo_nw.sv
// Self-checking bench for l2_cmd_fifo_nw: instance A (DEPTH=8, NWR=2) and
// instance B (DEPTH=4, NWR=3), checked against a queue-based reference model
// plus explicit expected-value tables and hand-written corner sequences.
module tb_l2_cmd_fifo_nw;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=8, NWR=2, AFULL_TH=6
    logic              rst_a = 1'b0;
    logic [1:0][W-1:0] din_a = '0;
    logic [1:0]        we_a  = '0;
    logic              re_a  = 1'b0;
    logic [W-1:0]      dout_a;
    logic              empty_a, full_a, af_a, ovf_a, udf_a;
    logic [3:0]        cnt_a, free_a;

    // Instance B: DEPTH=4, NWR=3, AFULL_TH=2
    logic              rst_b = 1'b0;
    logic [2:0][W-1:0] din_b = '0;
    logic [2:0]        we_b  = '0;
    logic              re_b  = 1'b0;
    logic [W-1:0]      dout_b;
    logic              empty_b, full_b, af_b, ovf_b, udf_b;
    logic [2:0]        cnt_b, free_b;

    l2_cmd_fifo_nw #(.WIDTH(W), .DEPTH(8), .NWR(2)) u_a (
        .clk(clk), .rst(rst_a), .din(din_a), .we(we_a), .re(re_a),
        .dout(dout_a), .empty(empty_a), .full(full_a), .almost_full(af_a),
        .count(cnt_a), .free(free_a), .overflow(ovf_a), .underflow(udf_a)
    );

    l2_cmd_fifo_nw #(.WIDTH(W), .DEPTH(4), .NWR(3)) u_b (
        .clk(clk), .rst(rst_b), .din(din_b), .we(we_b), .re(re_b),
        .dout(dout_b), .empty(empty_b), .full(full_b), .almost_full(af_b),
        .count(cnt_b), .free(free_b), .overflow(ovf_b), .underflow(udf_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one queue and sticky flags per instance.
    logic [W-1:0] mq_a[$];
    logic [W-1:0] mq_b[$];
    bit           m_ovf[2];
    bit           m_udf[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int popc3(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    task automatic model_step(input int id, input logic rn, input logic [2:0] we,
                              input logic [2:0][W-1:0] din, input logic re);
        int depth;
        int sz;
        int nw;
        bit acc;
        depth = (id == 0) ? 8 : 4;
        if (!rn) begin
            if (id == 0) mq_a.delete(); else mq_b.delete();
            m_ovf[id] = 0;
            m_udf[id] = 0;
            return;
        end
        sz  = (id == 0) ? mq_a.size() : mq_b.size();
        nw  = popc3(we);
        acc = (nw <= depth - sz);
        if (re) begin
            if (sz == 0) m_udf[id] = 1;
            else if (id == 0) void'(mq_a.pop_front());
            else void'(mq_b.pop_front());
        end
        if (acc) begin
            for (int p = 0; p < 3; p++) begin
                if (we[p]) begin
                    if (id == 0) mq_a.push_back(din[p]); else mq_b.push_back(din[p]);
                end
            end
        end else begin
            m_ovf[id] = 1;
        end
    endtask

    task automatic check_dut(input int id, input string tag);
        int sz;
        int depth;
        int th;
        logic [W-1:0] front;
        depth = (id == 0) ? 8 : 4;
        th    = depth - 2;
        sz    = (id == 0) ? mq_a.size() : mq_b.size();
        front = '0;
        if (sz > 0) front = (id == 0) ? mq_a[0] : mq_b[0];
        if (id == 0) begin
            chk({tag, ".count"}, 32'(cnt_a), 32'(sz));
            chk({tag, ".free"},  32'(free_a), 32'(depth - sz));
            chk({tag, ".empty"}, 32'(empty_a), 32'(sz == 0));
            chk({tag, ".full"},  32'(full_a), 32'(sz == depth));
            chk({tag, ".afull"}, 32'(af_a), 32'(sz >= th));
            chk({tag, ".ovf"},   32'(ovf_a), 32'(m_ovf[0]));
            chk({tag, ".udf"},   32'(udf_a), 32'(m_udf[0]));
            if (sz > 0) chk({tag, ".dout"}, 32'(dout_a), 32'(front));
        end else begin
            chk({tag, ".count"}, 32'(cnt_b), 32'(sz));
            chk({tag, ".free"},  32'(free_b), 32'(depth - sz));
            chk({tag, ".empty"}, 32'(empty_b), 32'(sz == 0));
            chk({tag, ".full"},  32'(full_b), 32'(sz == depth));
            chk({tag, ".afull"}, 32'(af_b), 32'(sz >= th));
            chk({tag, ".ovf"},   32'(ovf_b), 32'(m_ovf[1]));
            chk({tag, ".udf"},   32'(udf_b), 32'(m_udf[1]));
            if (sz > 0) chk({tag, ".dout"}, 32'(dout_b), 32'(front));
        end
    endtask

    // One clock of stimulus on one instance; the other is held idle.
    task automatic drive(input int id, input logic rn, input logic [2:0] we,
                         input logic [2:0][W-1:0] din, input logic re, input string tag);
        @(negedge clk);
        rst_a = 1'b1; we_a = '0; re_a = 1'b0;
        rst_b = 1'b1; we_b = '0; re_b = 1'b0;
        if (id == 0) begin
            rst_a = rn; we_a = we[1:0]; din_a = din[1:0]; re_a = re;
        end else begin
            rst_b = rn; we_b = we; din_b = din; re_b = re;
        end
        @(posedge clk);
        model_step(id, rn, we, din, re);
        #1;
        check_dut(id, tag);
    endtask

    typedef struct {
        logic [1:0]   we;
        logic [W-1:0] d1;
        logic [W-1:0] d0;
        logic         re;
        int           cnt;
        logic [W-1:0] dout;
        logic         emp;
        logic         full;
        logic         af;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [W-1:0] seq;
        int sz;

        // Fill/drain table for instance A: 4 double writes then 8 reads.
        for (int k = 0; k < 4; k++) begin
            tbl[k].we   = 2'b11;
            tbl[k].d1   = W'(2 * k + 1);
            tbl[k].d0   = W'(2 * k);
            tbl[k].re   = 1'b0;
            tbl[k].cnt  = 2 * k + 2;
            tbl[k].dout = 8'd0;
            tbl[k].emp  = 1'b0;
            tbl[k].full = (k == 3);
            tbl[k].af   = (2 * k + 2 >= 6);
        end
        for (int i = 0; i < 8; i++) begin
            tbl[4 + i].we   = 2'b00;
            tbl[4 + i].d1   = '0;
            tbl[4 + i].d0   = '0;
            tbl[4 + i].re   = 1'b1;
            tbl[4 + i].cnt  = 7 - i;
            tbl[4 + i].dout = W'(i + 1);
            tbl[4 + i].emp  = (i == 7);
            tbl[4 + i].full = 1'b0;
            tbl[4 + i].af   = (7 - i >= 6);
        end

        // Reset state of both instances.
        drive(0, 1'b0, 3'b000, '0, 1'b0, "rst_a");
        chk("rst_a.empty", 32'(empty_a), 32'd1);
        chk("rst_a.af", 32'(af_a), 32'd0);
        drive(1, 1'b0, 3'b000, '0, 1'b0, "rst_b");
        chk("rst_b.count", 32'(cnt_b), 32'd0);
        chk("rst_b.free", 32'(free_b), 32'd4);

        // Table-driven fill/drain.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b1, {1'b0, tbl[i].we}, {8'h00, tbl[i].d1, tbl[i].d0}, tbl[i].re, "fill");
            chk($sformatf("tbl%0d.count", i), 32'(cnt_a), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.empty", i), 32'(empty_a), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d.full", i), 32'(full_a), 32'(tbl[i].full));
            chk($sformatf("tbl%0d.afull", i), 32'(af_a), 32'(tbl[i].af));
            if (tbl[i].cnt > 0) chk($sformatf("tbl%0d.dout", i), 32'(dout_a), 32'(tbl[i].dout));
        end
        chk("fill.head0", 32'(tbl[0].cnt), 32'd2);

        // Overflow: count 7, then a 2-write group is dropped, then 1 fits.
        drive(0, 1'b1, 3'b011, {8'h0, 8'h11, 8'h10}, 1'b0, "ovf");
        drive(0, 1'b1, 3'b011, {8'h0, 8'h13, 8'h12}, 1'b0, "ovf");
        drive(0, 1'b1, 3'b011, {8'h0, 8'h15, 8'h14}, 1'b0, "ovf");
        drive(0, 1'b1, 3'b001, {8'h0, 8'h00, 8'h16}, 1'b0, "ovf");
        drive(0, 1'b1, 3'b011, {8'h0, 8'hEE, 8'hEF}, 1'b0, "ovf.drop");
        chk("ovf.drop.count", 32'(cnt_a), 32'd7);
        chk("ovf.drop.flag", 32'(ovf_a), 32'd1);
        drive(0, 1'b1, 3'b001, {8'h0, 8'h00, 8'h17}, 1'b0, "ovf.fit");
        chk("ovf.fit.count", 32'(cnt_a), 32'd8);
        chk("ovf.fit.full", 32'(full_a), 32'd1);
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 3'b000, '0, 1'b1, "ovf.drain");
        chk("ovf.sticky", 32'(ovf_a), 32'd1);

        // Same-cycle read and write while empty, then read+write while full.
        drive(0, 1'b0, 3'b000, '0, 1'b0, "udf.rst");
        drive(0, 1'b1, 3'b001, {8'h0, 8'h0, 8'h05}, 1'b1, "udf");
        chk("udf.count", 32'(cnt_a), 32'd1);
        chk("udf.dout", 32'(dout_a), 32'h05);
        chk("udf.flag", 32'(udf_a), 32'd1);
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 3'b011, {8'h0, W'(8'h21 + 2 * i), W'(8'h20 + 2 * i)}, 1'b0, "udf.fill");
        drive(0, 1'b1, 3'b001, {8'h0, 8'h0, 8'h26}, 1'b0, "udf.fill");
        chk("fullrw.pre", 32'(full_a), 32'd1);
        drive(0, 1'b1, 3'b001, {8'h0, 8'h0, 8'h99}, 1'b1, "fullrw");
        chk("fullrw.count", 32'(cnt_a), 32'd7);
        chk("fullrw.ovf", 32'(ovf_a), 32'd1);
        chk("fullrw.dout", 32'(dout_a), 32'h20);

        // Reset mid-operation at count 5 with active we/re.
        drive(0, 1'b1, 3'b000, '0, 1'b1, "mid");
        drive(0, 1'b1, 3'b000, '0, 1'b1, "mid");
        chk("mid.pre", 32'(cnt_a), 32'd5);
        drive(0, 1'b0, 3'b011, {8'h0, 8'hAB, 8'hCD}, 1'b1, "mid.rst");
        chk("mid.count", 32'(cnt_a), 32'd0);
        chk("mid.empty", 32'(empty_a), 32'd1);
        chk("mid.flags", 32'({ovf_a, udf_a}), 32'd0);
        drive(0, 1'b1, 3'b001, {8'h0, 8'h0, 8'h3C}, 1'b0, "mid.wr");
        chk("mid.dout", 32'(dout_a), 32'h3C);

        // Sparse ports on B: ports 0 and 2, then port 1 alone.
        drive(1, 1'b1, 3'b101, {8'hCC, 8'h55, 8'hAA}, 1'b0, "sparse");
        drive(1, 1'b1, 3'b010, {8'h00, 8'hBB, 8'h00}, 1'b0, "sparse");
        chk("sparse.count", 32'(cnt_b), 32'd3);
        chk("sparse.rd0", 32'(dout_b), 32'hAA);
        drive(1, 1'b1, 3'b000, '0, 1'b1, "sparse.rd");
        chk("sparse.rd1", 32'(dout_b), 32'hCC);
        drive(1, 1'b1, 3'b000, '0, 1'b1, "sparse.rd");
        chk("sparse.rd2", 32'(dout_b), 32'hBB);
        drive(1, 1'b1, 3'b000, '0, 1'b1, "sparse.rd");
        chk("sparse.empty", 32'(empty_b), 32'd1);

        // Pointer wrap on B with two-port groups and random pops.
        drive(1, 1'b0, 3'b000, '0, 1'b0, "wrap.rst");
        seq = 8'h40;
        for (int c = 0; c < 20; c++) begin
            logic [2:0] w;
            logic       r;
            sz = mq_b.size();
            r  = 1'($urandom_range(0, 1));
            if (4 - sz >= 2) w = 3'b011;
            else if (4 - sz >= 1) w = 3'b001;
            else w = 3'b000;
            drive(1, 1'b1, w, {8'h00, W'(seq + 8'd1), seq}, r, "wrap");
            seq = seq + 8'd2;
        end
        while (mq_b.size() > 0) drive(1, 1'b1, 3'b000, '0, 1'b1, "wrap.drain");
        chk("wrap.empty", 32'(empty_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
